// File: rtl/vga_if.sv
// VGA raster timing bundle between the timing source and the drawing stages.
// Pure wiring, no latency; no flow control, the stream advances every clock.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster counter with registered sync/blank decode; one clock from counter to port.
// Backpressure: none, never stalls; frame_start marks the (0,0) reached by a full-frame wrap.
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23
) (
    input  logic clk,
    input  logic rst,
    vga_if.out   vga_out,
    output logic frame_start
);

    localparam logic [10:0] H_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_LAST    = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] HBLNK_ON  = 11'(H_VISIBLE);
    localparam logic [10:0] HSYNC_ON  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HSYNC_OFF = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VBLNK_ON  = 11'(V_VISIBLE);
    localparam logic [10:0] VSYNC_ON  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VSYNC_OFF = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;

    // Flags are decoded from the next counter value so they land in the
    // same output cycle as the hcount/vcount they describe.
    always_comb begin
        h_d           = h_q + 11'd1;
        v_d           = v_q;
        frame_start_d = 1'b0;
        if (h_q == H_LAST) begin
            h_d = 11'd0;
            if (v_q == V_LAST) begin
                v_d           = 11'd0;
                frame_start_d = 1'b1;
            end else begin
                v_d = v_q + 11'd1;
            end
        end
        hblnk_d = (h_d >= HBLNK_ON);
        hsync_d = (h_d >= HSYNC_ON) && (h_d < HSYNC_OFF);
        vblnk_d = (v_d >= VBLNK_ON);
        vsync_d = (v_d >= VSYNC_ON) && (v_d < VSYNC_OFF);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q           <= 11'd0;
            v_q           <= 11'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_out.hcount = h_q;
    assign vga_out.vcount = v_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vblnk  = vblnk_q;
    assign vga_out.rgb    = 12'd0;
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x600 instance and a tiny-raster instance
// compared each cycle against an arithmetic model of position-since-reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst_d = 1'b0;
    logic rst_s = 1'b0;
    logic fs_d, fs_s;
    int   errors = 0;
    int   checks = 0;
    longint t_d = 0;
    longint t_s = 0;

    vga_if vga_d();
    vga_if vga_s();

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst_d), .vga_out(vga_d), .frame_start(fs_d)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .clk(clk), .rst(rst_s), .vga_out(vga_s), .frame_start(fs_s)
    );

    always #5 clk = ~clk;

    obs_t obs_d, obs_s;
    assign obs_d = {vga_d.hcount, vga_d.vcount, vga_d.hsync, vga_d.vsync,
                    vga_d.hblnk, vga_d.vblnk, vga_d.rgb, fs_d};
    assign obs_s = {vga_s.hcount, vga_s.vcount, vga_s.hsync, vga_s.vsync,
                    vga_s.hblnk, vga_s.vblnk, vga_s.rgb, fs_s};

    // Clocks elapsed since the last reset edge; zero while held in reset.
    always @(posedge clk) begin
        t_d <= rst_d ? t_d + 1 : 0;
        t_s <= rst_s ? t_s + 1 : 0;
    end

    // Expected outputs t clocks after reset, straight from the raster rules.
    function automatic obs_t model(input longint t, input longint hv, input longint hf,
                                   input longint hsw, input longint hbp, input longint vv,
                                   input longint vf, input longint vsw, input longint vbp);
        obs_t   e;
        longint ht = hv + hf + hsw + hbp;
        longint vt = vv + vf + vsw + vbp;
        longint h  = t % ht;
        longint v  = (t / ht) % vt;
        e.h   = h[10:0];
        e.v   = v[10:0];
        e.hs  = (h >= hv + hf) && (h < hv + hf + hsw);
        e.vs  = (v >= vv + vf) && (v < vv + vf + vsw);
        e.hb  = (h >= hv);
        e.vb  = (v >= vv);
        e.rgb = 12'd0;
        e.fs  = (t > 0) && (t % (ht * vt) == 0);
        return e;
    endfunction

    function automatic obs_t exp_d(input longint t);
        return model(t, 800, 40, 128, 88, 600, 1, 4, 23);
    endfunction

    function automatic obs_t exp_s(input longint t);
        return model(t, 16, 2, 3, 3, 8, 1, 2, 1);
    endfunction

    task automatic test_reset;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs_d !== 39'd0) begin
                errors++;
                $display("FAIL reset_d cycle=%0d got=%h exp=0", i, obs_d);
            end
            checks++;
            if (obs_s !== 39'd0) begin
                errors++;
                $display("FAIL reset_s cycle=%0d got=%h exp=0", i, obs_s);
            end
        end
        rst_d = 1'b1;
        rst_s = 1'b1;
        @(negedge clk);
        checks++;
        if (vga_d.hcount !== 11'd1 || vga_d.vcount !== 11'd0) begin
            errors++;
            $display("FAIL first_count got h=%0d v=%0d exp h=1 v=0", vga_d.hcount, vga_d.vcount);
        end
        checks++;
        if (obs_s !== exp_s(t_s)) begin
            errors++;
            $display("FAIL first_small got=%h exp=%h", obs_s, exp_s(t_s));
        end
    endtask

    task automatic test_horizontal;
        obs_t   prev;
        int     hs_cnt = 0;
        int     first_hs = -1;
        int     last_hs = -1;
        int     rise_h = -1;
        int     wraps = 0;
        prev = obs_d;
        for (int i = 0; i < 2200; i++) begin
            @(negedge clk);
            checks++;
            if (obs_d !== exp_d(t_d)) begin
                errors++;
                $display("FAIL horiz t=%0d got=%h exp=%h", t_d, obs_d, exp_d(t_d));
            end
            if (obs_d.v == 11'd1 && obs_d.hs) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(obs_d.h);
                last_hs = int'(obs_d.h);
            end
            if (obs_d.hb && !prev.hb && rise_h < 0) rise_h = int'(obs_d.h);
            if (prev.h == 11'd1055) begin
                wraps++;
                checks++;
                if (obs_d.h !== 11'd0 || obs_d.v !== prev.v + 11'd1) begin
                    errors++;
                    $display("FAIL hwrap got h=%0d v=%0d exp h=0 v=%0d", obs_d.h, obs_d.v, prev.v + 11'd1);
                end
            end
            prev = obs_d;
        end
        checks++;
        if (hs_cnt != 128 || first_hs != 840 || last_hs != 967) begin
            errors++;
            $display("FAIL hsync_span got cnt=%0d %0d..%0d exp cnt=128 840..967", hs_cnt, first_hs, last_hs);
        end
        checks++;
        if (rise_h != 800) begin
            errors++;
            $display("FAIL hblnk_rise got=%0d exp=800", rise_h);
        end
        checks++;
        if (wraps < 2) begin
            errors++;
            $display("FAIL hwrap_seen got=%0d exp>=2", wraps);
        end
    endtask

    task automatic test_small_frame;
        int  pulses = 0;
        int  last_pulse = -1;
        int  vs_cnt = 0;
        int  hs_cnt = 0;
        int  vs_min = 99, vs_max = -1, hs_min = 99, hs_max = -1;
        int  bad_sync = 0;
        int  last_h0 = -1;
        for (int i = 0; i < 3 * 288 + 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs_s !== exp_s(t_s)) begin
                errors++;
                $display("FAIL small t=%0d got=%h exp=%h", t_s, obs_s, exp_s(t_s));
            end
            if ((obs_s.hs && !obs_s.hb) || (obs_s.vs && !obs_s.vb)) bad_sync++;
            if (obs_s.h == 11'd0) begin
                if (last_h0 >= 0) begin
                    checks++;
                    if (i - last_h0 != 24) begin
                        errors++;
                        $display("FAIL line_period got=%0d exp=24", i - last_h0);
                    end
                end
                last_h0 = i;
            end
            if (obs_s.fs) begin
                checks++;
                if (obs_s.h !== 11'd0 || obs_s.v !== 11'd0) begin
                    errors++;
                    $display("FAIL fs_pos got h=%0d v=%0d exp 0,0", obs_s.h, obs_s.v);
                end
                if (last_pulse >= 0) begin
                    checks++;
                    if (i - last_pulse != 288) begin
                        errors++;
                        $display("FAIL fs_interval got=%0d exp=288", i - last_pulse);
                    end
                end
                pulses++;
                last_pulse = i;
            end
            if (pulses == 1) begin
                if (obs_s.vs) begin
                    vs_cnt++;
                    if (int'(obs_s.v) < vs_min) vs_min = int'(obs_s.v);
                    if (int'(obs_s.v) > vs_max) vs_max = int'(obs_s.v);
                end
                if (obs_s.hs) begin
                    hs_cnt++;
                    if (int'(obs_s.h) < hs_min) hs_min = int'(obs_s.h);
                    if (int'(obs_s.h) > hs_max) hs_max = int'(obs_s.h);
                end
            end
        end
        checks++;
        if (pulses < 3) begin
            errors++;
            $display("FAIL fs_count got=%0d exp>=3", pulses);
        end
        checks++;
        if (vs_cnt != 48 || vs_min != 9 || vs_max != 10) begin
            errors++;
            $display("FAIL vsync_span got cnt=%0d %0d..%0d exp cnt=48 9..10", vs_cnt, vs_min, vs_max);
        end
        checks++;
        if (hs_cnt != 36 || hs_min != 18 || hs_max != 20) begin
            errors++;
            $display("FAIL hsync_small got cnt=%0d %0d..%0d exp cnt=36 18..20", hs_cnt, hs_min, hs_max);
        end
        checks++;
        if (bad_sync != 0) begin
            errors++;
            $display("FAIL sync_unblanked got=%0d exp=0", bad_sync);
        end
    endtask

    task automatic test_mid_frame_reset;
        for (int k = 0; k < 6; k++) begin
            int th = $urandom_range(18, 20);
            int tv = $urandom_range(9, 10);
            int run = $urandom_range(300, 700);
            bit found = 1'b0;
            for (int i = 0; i < 400 && !found; i++) begin
                @(negedge clk);
                if (int'(obs_s.h) == th && int'(obs_s.v) == tv) found = 1'b1;
            end
            checks++;
            if (!found || !obs_s.hs || !obs_s.vs) begin
                errors++;
                $display("FAIL mid_target got found=%0d h=%0d v=%0d hs=%0d vs=%0d exp %0d,%0d in sync",
                         found, obs_s.h, obs_s.v, obs_s.hs, obs_s.vs, th, tv);
            end
            rst_s = 1'b0;
            @(negedge clk);
            checks++;
            if (obs_s !== 39'd0) begin
                errors++;
                $display("FAIL mid_reset got=%h exp=0", obs_s);
            end
            rst_s = 1'b1;
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                checks++;
                if (obs_s !== exp_s(t_s)) begin
                    errors++;
                    $display("FAIL mid_resume t=%0d got=%h exp=%h", t_s, obs_s, exp_s(t_s));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 8; k++) begin
            int run = $urandom_range(50, 1500);
            int hold = $urandom_range(1, 3);
            int which = $urandom_range(0, 2);
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                checks++;
                if (obs_d !== exp_d(t_d)) begin
                    errors++;
                    $display("FAIL b2b_d t=%0d got=%h exp=%h", t_d, obs_d, exp_d(t_d));
                end
                checks++;
                if (obs_s !== exp_s(t_s)) begin
                    errors++;
                    $display("FAIL b2b_s t=%0d got=%h exp=%h", t_s, obs_s, exp_s(t_s));
                end
            end
            if (which != 1) rst_d = 1'b0;
            if (which != 0) rst_s = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checks++;
                if (obs_d !== exp_d(t_d) || obs_s !== exp_s(t_s)) begin
                    errors++;
                    $display("FAIL b2b_rst got d=%h s=%h exp d=%h s=%h",
                             obs_d, obs_s, exp_d(t_d), exp_s(t_s));
                end
            end
            rst_d = 1'b1;
            rst_s = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_small_frame();
        test_mid_frame_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
